mips_multicycle_core: RTL and testbench
=======================================

// Module: mips_multicycle_core
// PURPOSE
//  Parametrised multicycle MIPS core: 32-bit datapath plus its own control FSM.
//  Sits between the top level and a single shared instruction/data memory.
//  Adds a req/ready memory handshake with variable latency and a configurable reset PC.
//  Adds illegal-opcode reporting and optional overflow trapping.
// PARAMETERS
//  ADDR_W    32     width of mem_addr; PC and addresses wrap modulo 2^ADDR_W
//  RESET_PC  0      PC value loaded by reset (ADDR_W bits)
//  TRAP_VEC  'h180  PC loaded on overflow trap (used only with OVF_TRAP_EN)
// PORTS
//  ck         in   1       clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  mem_req    out  1       memory access request
//  mem_we     out  1       1 = write, 0 = read; valid while mem_req=1
//  mem_addr   out  ADDR_W  byte address; valid while mem_req=1
//  mem_wdata  out  32      store data (register B); valid while mem_req & mem_we
//  mem_rdata  in   32      read data; sampled in the cycle mem_ready=1
//  mem_ready  in   1       completes the current request
//  overflow   out  1       sticky: set on signed overflow of add/sub/addi
//  illegal    out  1       one-cycle pulse on an undecodable opcode/funct
//  pc_o       out  ADDR_W  current PC (debug)
// BEHAVIOUR
//  Reset: PC=RESET_PC, state=FETCH, IR/A/B/ALUOut/MDR=0, regfile all 0.
//   Outputs during and after reset: mem_req=0 during reset; overflow=0; illegal=0.
//   Reset asserted in any state aborts the instruction; no regfile or memory write occurs in that cycle.
//  Handshake:
//   In FETCH, MEMRD and MEMWR, mem_req=1 and addr/we/wdata are held stable until the cycle with mem_ready=1.
//   The state advances only on mem_ready=1; an access takes 1+N cycles for N wait cycles.
//   mem_ready while mem_req=0 is ignored.
//   mem_req=0 in all other states.
//  FSM states and transitions:
//   FETCH  -> DECODE  on ready; IR<=rdata, PC<=PC+4
//   DECODE -> A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm)<<2); then by opcode:
//     0x23 lw / 0x2B sw -> MEMADR
//     0x00 R-type       -> EXEC
//     0x04 beq          -> BRANCH
//     0x08 addi         -> ADDIEX
//     0x02 j            -> JUMP
//     other             -> FETCH with illegal pulse
//   MEMADR -> ALUOut<=A+sext(imm); then MEMRD (lw) or MEMWR (sw)
//   MEMRD  -> MEMWB on ready; MDR<=rdata
//   MEMWB  -> rf[rt]<=MDR; -> FETCH
//   MEMWR  -> FETCH on ready
//   EXEC   -> funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed); ALUOut<=result
//     -> ALUWB; unknown funct -> FETCH with illegal pulse
//   ALUWB  -> rf[rd]<=ALUOut; -> FETCH
//   BRANCH -> if A==B then PC<=ALUOut; -> FETCH
//   ADDIEX -> ALUOut<=A+sext(imm); -> ADDIWB
//   ADDIWB -> rf[rt]<=ALUOut; -> FETCH
//   JUMP   -> PC<={PC[31:28], IR[25:0], 2'b00} truncated to ADDR_W; -> FETCH
//  Arithmetic: 32-bit two's complement; results wrap; mem_addr=ALUOut[ADDR_W-1:0]; no alignment check.
//  Register $0: reads always 0; writes to $0 discarded.
//  Overflow: signed overflow in add/sub/addi only; and/or/slt and address/PC adds never flag it.
//  CPI: lw 5, sw/R-type/addi 4, beq/j 3, each plus memory wait cycles.
// CONFIGURATION
//  OVF_TRAP_EN undefined: on overflow, the wrapped result is written back and overflow sets sticky.
//  OVF_TRAP_EN defined: on overflow, writeback is suppressed, overflow sets, EPC<=address of the
//   faulting instruction (PC-4), next state is FETCH with PC<=TRAP_VEC.
//   Adds output epc_o [ADDR_W], reset value 0.
// TESTING
//  1 Reset with RESET_PC='h40, mem_ready=1 -> first mem_addr='h40, mem_req=1, mem_we=0.
//  2 addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0) -> write addr 0x10, wdata 12.
//  3 Same program with mem_ready delayed 3 cycles per access -> identical results; addr/wdata stable while waiting.
//  4 beq $1,$1,+2 at 0x0 -> next fetch 0xC; beq with unequal regs -> next fetch 0x4; j 0x40 -> next fetch 0x100.
//  5 addi $1,$0,0x7FFF; add large values 0x7FFFFFFF+1 -> overflow=1; $ gets 0x80000000 (no trap).
//    With OVF_TRAP_EN: no write, PC=TRAP_VEC, epc_o=faulting PC.
//  6 opcode 0x3F -> illegal pulses 1 cycle, no state change, next fetch PC+4;
//    reset asserted mid-MEMWR wait -> no write, PC=RESET_PC.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// rtl/mips_multicycle_core_if.sv - shared instruction/data memory req/ready bus
interface mips_multicycle_core_if #(parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS core with variable-latency memory port
// Optional OVF_TRAP_EN: signed overflow suppresses writeback, traps to TRAP_VEC, reports epc_o.
module mips_multicycle_core #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef OVF_TRAP_EN
  , parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'('h180)
`endif
) (
  input  logic               ck,
  input  logic               reset,
  mips_multicycle_core_if.master bus,
  output logic               overflow,
  output logic               illegal,
  output logic [ADDR_W-1:0]  pc_o
`ifdef OVF_TRAP_EN
  , output logic [ADDR_W-1:0] epc_o
`endif
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc, addr_q;
  logic [31:0]       ir, a, b, alu_out, mdr, wdata_q;
  logic              req_q, we_q;
  logic [31:0]       rf [32];
`ifdef OVF_TRAP_EN
  logic [ADDR_W-1:0] epc;
`endif

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm, pc32, sum, diff, alu_res, addi_sum;
  logic              alu_ok, alu_ovf, addi_ovf;
  logic [ADDR_W-1:0] jump_pc;

  always_comb begin
    op       = ir[31:26];
    rs       = ir[25:21];
    rt       = ir[20:16];
    rd       = ir[15:11];
    funct    = ir[5:0];
    imm      = {{16{ir[15]}}, ir[15:0]};
    pc32     = 32'(pc);
    sum      = a + b;
    diff     = a - b;
    addi_sum = a + imm;
    addi_ovf = (a[31] == imm[31]) && (addi_sum[31] != a[31]);
    jump_pc  = ADDR_W'({pc32[31:28], ir[25:0], 2'b00});
    alu_ok   = 1'b1;
    alu_ovf  = 1'b0;
    alu_res  = '0;
    case (funct)
      6'h20: begin alu_res = sum;  alu_ovf = (a[31] == b[31]) && (sum[31] != a[31]);  end
      6'h22: begin alu_res = diff; alu_ovf = (a[31] != b[31]) && (diff[31] != a[31]); end
      6'h24: alu_res = a & b;
      6'h25: alu_res = a | b;
      6'h2A: alu_res = {31'b0, $signed(a) < $signed(b)};
      default: alu_ok = 1'b0;
    endcase
  end

  // Bus outputs are registered on entry to FETCH/MEMRD/MEMWR so they hold through wait cycles.
  always_ff @(posedge ck) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b1;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
`ifdef OVF_TRAP_EN
      epc      <= '0;
`endif
    end else begin
      illegal <= 1'b0;
      case (state)
        FETCH: if (bus.mem_ready) begin
          ir    <= bus.mem_rdata;
          pc    <= pc + ADDR_W'(4);
          req_q <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc32 + {imm[29:0], 2'b00};
          case (op)
            6'h23, 6'h2B: state <= MEMADR;
            6'h00:        state <= EXEC;
            6'h04:        state <= BRANCH;
            6'h08:        state <= ADDIEX;
            6'h02:        state <= JUMP;
            default: begin
              illegal <= 1'b1;
              req_q   <= 1'b1;
              addr_q  <= pc;
              state   <= FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_out <= addi_sum;
          addr_q  <= ADDR_W'(addi_sum);
          req_q   <= 1'b1;
          we_q    <= (op == 6'h2B);
          wdata_q <= b;
          state   <= (op == 6'h2B) ? MEMWR : MEMRD;
        end
        MEMRD: if (bus.mem_ready) begin
          mdr   <= bus.mem_rdata;
          req_q <= 1'b0;
          state <= MEMWB;
        end
        MEMWB: begin
          if (rt != 5'd0) rf[rt] <= mdr;
          req_q  <= 1'b1;
          addr_q <= pc;
          state  <= FETCH;
        end
        MEMWR: if (bus.mem_ready) begin
          we_q   <= 1'b0;
          addr_q <= pc;
          state  <= FETCH;
        end
        EXEC: begin
          if (!alu_ok) begin
            illegal <= 1'b1;
            req_q   <= 1'b1;
            addr_q  <= pc;
            state   <= FETCH;
          end else begin
            alu_out <= alu_res;
            if (alu_ovf) overflow <= 1'b1;
`ifdef OVF_TRAP_EN
            if (alu_ovf) begin
              epc    <= pc - ADDR_W'(4);
              pc     <= TRAP_VEC;
              addr_q <= TRAP_VEC;
              req_q  <= 1'b1;
              state  <= FETCH;
            end else state <= ALUWB;
`else
            state <= ALUWB;
`endif
          end
        end
        ALUWB: begin
          if (rd != 5'd0) rf[rd] <= alu_out;
          req_q  <= 1'b1;
          addr_q <= pc;
          state  <= FETCH;
        end
        BRANCH: begin
          if (a == b) begin
            pc     <= ADDR_W'(alu_out);
            addr_q <= ADDR_W'(alu_out);
          end else addr_q <= pc;
          req_q <= 1'b1;
          state <= FETCH;
        end
        ADDIEX: begin
          alu_out <= addi_sum;
          if (addi_ovf) overflow <= 1'b1;
`ifdef OVF_TRAP_EN
          if (addi_ovf) begin
            epc    <= pc - ADDR_W'(4);
            pc     <= TRAP_VEC;
            addr_q <= TRAP_VEC;
            req_q  <= 1'b1;
            state  <= FETCH;
          end else state <= ADDIWB;
`else
          state <= ADDIWB;
`endif
        end
        ADDIWB: begin
          if (rt != 5'd0) rf[rt] <= alu_out;
          req_q  <= 1'b1;
          addr_q <= pc;
          state  <= FETCH;
        end
        JUMP: begin
          pc     <= jump_pc;
          addr_q <= jump_pc;
          req_q  <= 1'b1;
          state  <= FETCH;
        end
        default: begin
          req_q  <= 1'b1;
          addr_q <= pc;
          state  <= FETCH;
        end
      endcase
    end
  end

  assign bus.mem_req   = req_q & ~reset;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign pc_o          = pc;
`ifdef OVF_TRAP_EN
  assign epc_o         = epc;
`endif
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - self-checking bench for mips_multicycle_core
module tb_mips_multicycle_core;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h40;

  logic ck = 1'b0;
  logic reset = 1'b1;
  logic overflow, illegal;
  logic [ADDR_W-1:0] pc_o;
`ifdef OVF_TRAP_EN
  logic [ADDR_W-1:0] epc_o;
`endif

  mips_multicycle_core_if #(.ADDR_W(ADDR_W)) bus ();

  mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .ck(ck), .reset(reset), .bus(bus),
    .overflow(overflow), .illegal(illegal), .pc_o(pc_o)
`ifdef OVF_TRAP_EN
    , .epc_o(epc_o)
`endif
  );

  always #5 ck = ~ck;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } ev_t;

  ev_t         exp_wr[$], wr_log[$], exp_rd[$], rd_log[$];
  logic [31:0] prog[$];
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  int cyc = 0, rel = 0, wait_cycles = 0, wcnt = 0, ill_cnt = 0, unstable = 0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  always @(posedge ck) cyc++;

  // Memory slave: inserts wait_cycles wait states per access, logs completed accesses.
  always @(negedge ck) begin
    if (illegal === 1'b1 && !reset) ill_cnt++;
    if (reset || bus.mem_req !== 1'b1) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = '0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        h_addr = bus.mem_addr; h_we = bus.mem_we; h_wdata = bus.mem_wdata;
      end else if (bus.mem_addr !== h_addr || bus.mem_we !== h_we ||
                   (h_we && bus.mem_wdata !== h_wdata)) unstable++;
      if (wcnt < wait_cycles) begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end else begin
        bus.mem_ready = 1'b1;
        wcnt = 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          wr_log.push_back('{bus.mem_addr, bus.mem_wdata, cyc - rel});
        end else begin
          bus.mem_rdata = mem[bus.mem_addr[9:2]];
          rd_log.push_back('{bus.mem_addr, mem[bus.mem_addr[9:2]], cyc - rel});
        end
      end
    end
  end

  function automatic logic [31:0] f_addi(input int rt, input int rs, input logic [15:0] imm);
    return {6'h08, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] f_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] f_mem(input logic [5:0] op, input int rt, input int base, input logic [15:0] off);
    return {op, 5'(base), 5'(rt), off};
  endfunction
  function automatic logic [31:0] f_beq(input int rs, input int rt, input logic [15:0] off);
    return {6'h04, 5'(rs), 5'(rt), off};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] target);
    return {6'h02, target[27:2]};
  endfunction

  task automatic start_reset();
    reset = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    foreach (mem[i]) mem[i] = '0;
    prog.delete(); exp_wr.delete(); exp_rd.delete(); wr_log.delete(); rd_log.delete();
    ill_cnt = 0; unstable = 0;
  endtask

  task automatic load_prog();
    foreach (prog[i]) mem[(RST_PC >> 2) + i] = prog[i];
  endtask

  task automatic release_reset(input int w);
    wait_cycles = w;
    @(posedge ck);
    #1;
    reset = 1'b0;
    rel = cyc;
    wr_log.delete(); rd_log.delete();
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_log.size() < n && k < budget) begin @(posedge ck); k++; end
    #1;
    ok = (wr_log.size() >= n);
  endtask

  task automatic wait_rd(input int n, input int budget, output bit ok);
    int k = 0;
    while (rd_log.size() < n && k < budget) begin @(posedge ck); k++; end
    #1;
    ok = (rd_log.size() >= n);
  endtask

  task automatic test_reset();
    start_reset();
    load_prog();
    @(negedge ck);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_ill: got %b want 0", illegal); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, RST_PC); end
    release_reset(0);
    @(negedge ck);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== RST_PC) begin errors++; $display("FAIL first_addr: got %h want %h", bus.mem_addr, RST_PC); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL first_we: got %b want 0", bus.mem_we); end
  endtask

  task automatic test_program(input int w);
    ev_t e, a;
    bit ok;
    start_reset();
    prog.push_back(f_addi(1, 0, 16'd5));
    prog.push_back(f_addi(2, 0, 16'd7));
    prog.push_back(f_r(3, 1, 2, 6'h20));
    prog.push_back(f_mem(6'h2B, 3, 0, 16'h10));
    prog.push_back(f_mem(6'h23, 4, 0, 16'h10));
    prog.push_back(f_addi(4, 4, 16'd1));
    prog.push_back(f_mem(6'h2B, 4, 0, 16'h14));
    prog.push_back(f_j(32'h5C));
    exp_wr.push_back('{32'h10, 32'd12, 15 + 5 * w});
    exp_wr.push_back('{32'h14, 32'd13, 28 + 10 * w});
    load_prog();
    release_reset(w);
    wait_wr(2, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prog_timeout w=%0d: got %0d writes want 2", w, wr_log.size()); end
    while (exp_wr.size() > 0 && wr_log.size() > 0) begin
      e = exp_wr.pop_front(); a = wr_log.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data || a.cyc !== e.cyc) begin
        errors++;
        $display("FAIL prog_write w=%0d: got addr %h data %h cyc %0d want addr %h data %h cyc %0d",
                 w, a.addr, a.data, a.cyc, e.addr, e.data, e.cyc);
      end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL prog_stable w=%0d: got %0d changes want 0", w, unstable); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL prog_ovf w=%0d: got %b want 0", w, overflow); end
  endtask

  task automatic test_alu();
    ev_t e, a;
    bit ok;
    logic [31:0] st_addr;
    start_reset();
    prog.push_back(f_addi(1, 0, 16'hFFFD));
    prog.push_back(f_addi(2, 0, 16'd5));
    prog.push_back(f_r(3, 1, 2, 6'h22));
    prog.push_back(f_r(4, 1, 2, 6'h24));
    prog.push_back(f_r(5, 1, 2, 6'h25));
    prog.push_back(f_r(6, 1, 2, 6'h2A));
    prog.push_back(f_r(7, 2, 1, 6'h2A));
    prog.push_back(f_addi(0, 0, 16'd9));
    for (int r = 3; r <= 8; r++) begin
      st_addr = 32'h10 + 32'((r - 3) * 4);
      prog.push_back(f_mem(6'h2B, (r == 8) ? 0 : r, 0, st_addr[15:0]));
    end
    prog.push_back(f_j(32'h78));
    exp_wr.push_back('{32'h10, 32'hFFFF_FFF8, -1});
    exp_wr.push_back('{32'h14, 32'h0000_0005, -1});
    exp_wr.push_back('{32'h18, 32'hFFFF_FFFD, -1});
    exp_wr.push_back('{32'h1C, 32'h0000_0001, -1});
    exp_wr.push_back('{32'h20, 32'h0000_0000, -1});
    exp_wr.push_back('{32'h24, 32'h0000_0000, -1});
    load_prog();
    release_reset(0);
    wait_wr(6, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_timeout: got %0d writes want 6", wr_log.size()); end
    while (exp_wr.size() > 0 && wr_log.size() > 0) begin
      e = exp_wr.pop_front(); a = wr_log.pop_front();
      checks++;
      if (a.addr !== e.addr || a.data !== e.data) begin
        errors++;
        $display("FAIL alu_write: got addr %h data %h want addr %h data %h", a.addr, a.data, e.addr, e.data);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL alu_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_branch_jump();
    ev_t e, a;
    bit ok;
    int s;
    int cpi [6] = '{4, 3, 3, 3, 3, 3};
    logic [31:0] fa [6] = '{32'h40, 32'h44, 32'h50, 32'h54, 32'h100, 32'h100};
    start_reset();
    prog.push_back(f_addi(1, 0, 16'd1));
    prog.push_back(f_beq(1, 1, 16'd2));
    prog.push_back(32'hFC00_0000);
    prog.push_back(32'hFC00_0000);
    prog.push_back(f_beq(1, 0, 16'd5));
    prog.push_back(f_j(32'h100));
    load_prog();
    mem[32'h100 >> 2] = f_j(32'h100);
    s = 0;
    for (int i = 0; i < 6; i++) begin
      exp_rd.push_back('{fa[i], 32'h0, s + 1});
      s += cpi[i] + 1;
    end
    release_reset(1);
    wait_rd(6, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL br_timeout: got %0d fetches want 6", rd_log.size()); end
    while (exp_rd.size() > 0 && rd_log.size() > 0) begin
      e = exp_rd.pop_front(); a = rd_log.pop_front();
      checks++;
      if (a.addr !== e.addr || a.cyc !== e.cyc) begin
        errors++;
        $display("FAIL br_fetch: got addr %h cyc %0d want addr %h cyc %0d", a.addr, a.cyc, e.addr, e.cyc);
      end
    end
    checks++; if (ill_cnt !== 0) begin errors++; $display("FAIL br_illegal: got %0d pulses want 0", ill_cnt); end
  endtask

  task automatic test_overflow();
    ev_t a;
    bit ok;
    start_reset();
    prog.push_back(f_mem(6'h23, 1, 0, 16'h20));
    prog.push_back(f_addi(2, 0, 16'd1));
    prog.push_back(f_r(4, 0, 2, 6'h22));
    prog.push_back(f_mem(6'h2B, 4, 0, 16'h28));
    prog.push_back(f_r(3, 1, 2, 6'h20));
    prog.push_back(f_mem(6'h2B, 3, 0, 16'h24));
    prog.push_back(f_j(32'h58));
    load_prog();
    mem[8] = 32'h7FFF_FFFF;
    release_reset(0);
    wait_wr(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout1: got %0d writes want 1", wr_log.size()); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
    wait_wr(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout2: got %0d writes want 2", wr_log.size()); end
    if (wr_log.size() >= 2) begin
      a = wr_log[0];
      checks++; if (a.data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_sub: got %h want ffffffff", a.data); end
      a = wr_log[1];
      checks++; if (a.addr !== 32'h24 || a.data !== 32'h8000_0000) begin errors++; $display("FAIL ovf_add: got addr %h data %h want addr 24 data 80000000", a.addr, a.data); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_add_flag: got %b want 1", overflow); end

    start_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    prog.push_back(f_mem(6'h23, 1, 0, 16'h20));
    prog.push_back(f_addi(2, 1, 16'd1));
    prog.push_back(f_mem(6'h2B, 2, 0, 16'h24));
    prog.push_back(f_j(32'h4C));
    load_prog();
    mem[8] = 32'h7FFF_FFFF;
    release_reset(0);
    wait_wr(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL addi_timeout: got %0d writes want 1", wr_log.size()); end
    if (wr_log.size() >= 1) begin
      a = wr_log[0];
      checks++; if (a.data !== 32'h8000_0000) begin errors++; $display("FAIL addi_ovf_data: got %h want 80000000", a.data); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL addi_ovf_flag: got %b want 1", overflow); end
  endtask

  task automatic test_illegal();
    ev_t e, a;
    bit ok;
    start_reset();
    prog.push_back(32'hFC00_0000);
    prog.push_back(f_r(3, 1, 2, 6'h3F));
    prog.push_back(f_addi(1, 0, 16'd3));
    prog.push_back(f_mem(6'h2B, 1, 0, 16'h10));
    prog.push_back(f_j(32'h50));
    load_prog();
    exp_rd.push_back('{32'h40, 32'h0, 0});
    exp_rd.push_back('{32'h44, 32'h0, 2});
    exp_rd.push_back('{32'h48, 32'h0, 5});
    exp_rd.push_back('{32'h4C, 32'h0, 9});
    release_reset(0);
    wait_wr(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ill_timeout: got %0d writes want 1", wr_log.size()); end
    while (exp_rd.size() > 0 && rd_log.size() > 0) begin
      e = exp_rd.pop_front(); a = rd_log.pop_front();
      checks++;
      if (a.addr !== e.addr || a.cyc !== e.cyc) begin
        errors++;
        $display("FAIL ill_fetch: got addr %h cyc %0d want addr %h cyc %0d", a.addr, a.cyc, e.addr, e.cyc);
      end
    end
    if (wr_log.size() >= 1) begin
      a = wr_log[0];
      checks++; if (a.data !== 32'd3) begin errors++; $display("FAIL ill_write: got %h want 3", a.data); end
    end
    checks++; if (ill_cnt !== 2) begin errors++; $display("FAIL ill_pulses: got %0d cycles want 2", ill_cnt); end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int k;
    start_reset();
    prog.push_back(f_addi(1, 0, 16'd9));
    prog.push_back(f_mem(6'h2B, 1, 0, 16'h10));
    prog.push_back(f_j(32'h48));
    load_prog();
    release_reset(20);
    k = 0;
    do begin @(negedge ck); k++; end while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b1) && k < 300);
    checks++; if (k >= 300) begin errors++; $display("FAIL mid_timeout: got no write request want one"); end
    @(posedge ck); #1;
    reset = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL mid_nowrite: got %0d writes want 0", wr_log.size()); end
    checks++; if (mem[4] !== 32'h0) begin errors++; $display("FAIL mid_mem: got %h want 0", mem[4]); end
    checks++; if (pc_o !== RST_PC) begin errors++; $display("FAIL mid_pc: got %h want %h", pc_o, RST_PC); end
    release_reset(0);
    wait_rd(1, 50, ok);
    checks++;
    if (!ok || rd_log[0].addr !== RST_PC || rd_log[0].cyc !== 0) begin
      errors++;
      $display("FAIL mid_refetch: got %0d fetches addr %h want addr %h cyc 0", rd_log.size(),
               ok ? rd_log[0].addr : 32'hx, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_program(0);
    test_program(3);
    test_alu();
    test_branch_jump();
    test_overflow();
    test_illegal();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
